// File: rtl/led_trail_pwm_if.sv
// led_trail_pwm_if: signal bundle between the LED scanner and the trail/PWM stage.
//   led_in     scanner on/off pattern (may come from an unrelated clock)
//   enable     1 = run, 0 = blank outputs and clear brightness
//   led_out    PWM-modulated LED drive
//   decay_tick one-cycle pulse on each decay event
// master = scanner/board side, slave = led_trail_pwm.
interface led_trail_pwm_if #(
  parameter int N_LEDS = 8
);
  logic [N_LEDS-1:0] led_in;
  logic              enable;
  logic [N_LEDS-1:0] led_out;
  logic              decay_tick;

  modport master (output led_in, enable, input  led_out, decay_tick);
  modport slave  (input  led_in, enable, output led_out, decay_tick);
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: turns the scanner on/off pattern into a fading trail.
// A lit input loads full brightness; after it drops, brightness decays by
// DECAY_STEP on each decay tick. Each channel is PWM-compared against a shared
// free-running counter.
// Ports:
//   clk   system clock, rising edge
//   rstn  synchronous active-low reset
//   bus   led_trail_pwm_if.slave (led_in, enable in; led_out, decay_tick out)

// Per-channel brightness register and PWM comparator.
module led_trail_lane #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                led_s,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] bright;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bright  <= '0;
      led_out <= 1'b0;
    end else begin
      // load beats a coincident decay tick; subtract saturates at 0
      if (!enable)          bright <= '0;
      else if (led_s)       bright <= MAX;
      else if (decay_tick)  bright <= (bright > STEP) ? bright - STEP : '0;

      // MAX is forced on so full brightness never shows the one-cycle gap
      // that bright > pwm_cnt alone would leave at pwm_cnt==MAX
      led_out <= enable & ((bright == MAX) | (bright > pwm_cnt));
    end
  end
endmodule

module led_trail_pwm #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 1048576,
  parameter int DECAY_STEP = 32
) (
  input  logic            clk,
  input  logic            rstn,
  led_trail_pwm_if.slave  bus
);
  localparam int              DIV_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   sync_q1;
  logic [N_LEDS-1:0]   led_s;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                decay_tick_q;
  logic [N_LEDS-1:0]   led_out_q;

  // 2-flop synchronizer on led_in plus shared counters; counters keep
  // running while enable is low so PWM phase is unaffected by blanking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q1      <= '0;
      led_s        <= '0;
      pwm_cnt      <= '0;
      div_cnt      <= '0;
      decay_tick_q <= 1'b0;
    end else begin
      sync_q1      <= bus.led_in;
      led_s        <= sync_q1;
      pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
      div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      decay_tick_q <= (div_cnt == DIV_LAST);
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    led_trail_lane #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (bus.enable),
      .led_s     (led_s[i]),
      .decay_tick(decay_tick_q),
      .pwm_cnt   (pwm_cnt),
      .led_out   (led_out_q[i])
    );
  end

  assign bus.led_out    = led_out_q;
  assign bus.decay_tick = decay_tick_q;
endmodule
